uart_ahb_bridge: RTL and testbench

UART_AHB_BRIDGE -- requirements
Module: uart_ahb_bridge

---
 rtl/uart_ahb_bridge_pkg.sv | 31 +++
 rtl/uart_ahb_bridge_uart.sv | 112 +++++++++++
 rtl/uart_ahb_bridge.sv | 165 ++++++++++++++++
 tb/tb_uart_ahb_bridge.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ahb_bridge_pkg.sv
// Shared constants for the UART-to-AHB bridge: frame opcodes, AHB encodings,
// FSM state encoding and the oversampling phases used by the uart core.
package uart_ahb_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // uart core runs 8 baud ticks per bit; RX samples near mid-bit
    localparam logic [2:0] UART_LAST_TICK = 3'd7;
    localparam logic [2:0] UART_MID_TICK  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS_ADDR,
        ST_BUS_DATA,
        ST_SEND
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_ahb_bridge_uart.sv
// 8N1 uart core: fractional baud accumulator, 8x oversampled receiver and a
// transmitter with a busy flag. Reset is synchronous, active-low.
module uart_ahb_bridge_uart
    import uart_ahb_bridge_pkg::*;
(
    input  logic        CLK_I,
    input  logic        RST_N_I,
    input  logic [10:0] ADD_I,
    input  logic        RX_I,
    output logic        TX_O,
    output logic [7:0]  RX_DATA_O,
    output logic        RX_VALID_O,
    input  logic [7:0]  TX_DATA_I,
    input  logic        TX_VALID_I,
    output logic        TX_BUSY_O
);

    logic [10:0] acc_reg;
    logic [11:0] acc_sum;
    logic        tick;

    logic [1:0]  rx_sync_reg;
    logic        rx_active_reg;
    logic [2:0]  rx_tick_reg;
    logic [3:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg;
    logic [7:0]  rx_data_reg;
    logic        rx_valid_reg;

    logic [9:0]  tx_shift_reg;
    logic [2:0]  tx_tick_reg;
    logic [3:0]  tx_bit_reg;
    logic        tx_busy_reg;

    assign acc_sum = {1'b0, acc_reg} + {1'b0, ADD_I};
    assign tick    = acc_sum[11];

    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) acc_reg <= '0;
        else          acc_reg <= acc_sum[10:0];
    end

    // bit 0 is the start bit, 1..8 data (LSB first), 9 the stop bit
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            rx_sync_reg   <= 2'b11;
            rx_active_reg <= 1'b0;
            rx_tick_reg   <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
        end else begin
            rx_sync_reg  <= {rx_sync_reg[0], RX_I};
            rx_valid_reg <= 1'b0;
            if (tick) begin
                if (!rx_active_reg) begin
                    if (!rx_sync_reg[1]) begin
                        rx_active_reg <= 1'b1;
                        rx_tick_reg   <= '0;
                        rx_bit_reg    <= '0;
                    end
                end else begin
                    rx_tick_reg <= rx_tick_reg + 3'd1;
                    if (rx_tick_reg == UART_MID_TICK) begin
                        rx_bit_reg <= rx_bit_reg + 4'd1;
                        if (rx_bit_reg == 4'd0) begin
                            if (rx_sync_reg[1]) rx_active_reg <= 1'b0;
                        end else if (rx_bit_reg == 4'd9) begin
                            rx_active_reg <= 1'b0;
                            if (rx_sync_reg[1]) begin
                                rx_valid_reg <= 1'b1;
                                rx_data_reg  <= rx_shift_reg;
                            end
                        end else begin
                            rx_shift_reg <= {rx_sync_reg[1], rx_shift_reg[7:1]};
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            tx_shift_reg <= '1;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_busy_reg  <= 1'b0;
        end else if (!tx_busy_reg) begin
            if (TX_VALID_I) begin
                tx_shift_reg <= {1'b1, TX_DATA_I, 1'b0};
                tx_tick_reg  <= '0;
                tx_bit_reg   <= '0;
                tx_busy_reg  <= 1'b1;
            end
        end else if (tick) begin
            tx_tick_reg <= tx_tick_reg + 3'd1;
            if (tx_tick_reg == UART_LAST_TICK) begin
                tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
                tx_bit_reg   <= tx_bit_reg + 4'd1;
                if (tx_bit_reg == 4'd9) tx_busy_reg <= 1'b0;
            end
        end
    end

    assign TX_O       = tx_busy_reg ? tx_shift_reg[0] : 1'b1;
    assign TX_BUSY_O  = tx_busy_reg;
    assign RX_DATA_O  = rx_data_reg;
    assign RX_VALID_O = rx_valid_reg;

endmodule

// File: rtl/uart_ahb_bridge.sv
// UART-framed AHB initiator: 'W' addr data / 'R' addr frames become single
// 32-bit NONSEQ transfers; the result is returned as 'K', 'E' or 4 data bytes.
module uart_ahb_bridge
    import uart_ahb_bridge_pkg::*;
#(
    parameter logic [10:0] CLK_ADD = 11'd629,
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic        HCLK_I,
    input  logic        HRESET_I,
    input  logic        RX_I,
    output logic        TX_O,
    output logic [31:0] HADDR_O,
    output logic [1:0]  HTRANS_O,
    output logic        HWRITE_O,
    output logic [2:0]  HSIZE_O,
    output logic [31:0] HWDATA_O,
    input  logic [31:0] HRDATA_I,
    input  logic        HREADY_I,
    input  logic        HRESP_I,
    output logic        BUSY_O
);

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_busy;

    state_t      state_reg;
    logic [1:0]  byte_cnt_reg;
    logic [23:0] timeout_cnt_reg;
    logic        is_write_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic [31:0] haddr_reg;
    logic [31:0] hwdata_reg;
    logic        hwrite_reg;
    logic [31:0] resp_reg;
    logic        err_reg;
    logic        tx_valid_reg;
    logic [7:0]  tx_data_reg;
    logic        guard_reg;
    logic        last_byte;

    uart_ahb_bridge_uart u_uart (
        .CLK_I      (HCLK_I),
        .RST_N_I    (~HRESET_I),
        .ADD_I      (CLK_ADD),
        .RX_I       (RX_I),
        .TX_O       (TX_O),
        .RX_DATA_O  (rx_data),
        .RX_VALID_O (rx_valid),
        .TX_DATA_I  (tx_data_reg),
        .TX_VALID_I (tx_valid_reg),
        .TX_BUSY_O  (tx_busy)
    );

    assign last_byte = err_reg || is_write_reg || (byte_cnt_reg == 2'd3);

    always_ff @(posedge HCLK_I) begin
        if (HRESET_I) begin
            state_reg       <= ST_IDLE;
            byte_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
            is_write_reg    <= 1'b0;
            addr_reg        <= '0;
            data_reg        <= '0;
            haddr_reg       <= '0;
            hwdata_reg      <= '0;
            hwrite_reg      <= 1'b0;
            resp_reg        <= '0;
            err_reg         <= 1'b0;
            tx_valid_reg    <= 1'b0;
            tx_data_reg     <= '0;
            guard_reg       <= 1'b0;
        end else begin
            tx_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (rx_valid && is_opcode(rx_data)) begin
                        state_reg       <= ST_GET_ADDR;
                        is_write_reg    <= (rx_data == OP_WRITE);
                        byte_cnt_reg    <= '0;
                        timeout_cnt_reg <= '0;
                    end
                end
                ST_GET_ADDR, ST_GET_DATA: begin
                    // timeout wins; a coincident byte is re-parsed as an opcode
                    if (timeout_cnt_reg == TIMEOUT - 24'd1) begin
                        byte_cnt_reg    <= '0;
                        timeout_cnt_reg <= '0;
                        if (rx_valid && is_opcode(rx_data)) begin
                            state_reg    <= ST_GET_ADDR;
                            is_write_reg <= (rx_data == OP_WRITE);
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else if (rx_valid) begin
                        timeout_cnt_reg <= '0;
                        if (state_reg == ST_GET_ADDR) addr_reg <= {addr_reg[23:0], rx_data};
                        else                          data_reg <= {data_reg[23:0], rx_data};
                        if (byte_cnt_reg == 2'd3) begin
                            byte_cnt_reg <= '0;
                            if (state_reg == ST_GET_ADDR && is_write_reg) begin
                                state_reg <= ST_GET_DATA;
                            end else begin
                                state_reg  <= ST_BUS_ADDR;
                                hwrite_reg <= is_write_reg;
                                haddr_reg  <= (state_reg == ST_GET_ADDR) ?
                                              {addr_reg[23:0], rx_data} : addr_reg;
                                if (is_write_reg) hwdata_reg <= {data_reg[23:0], rx_data};
                            end
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        end
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 24'd1;
                    end
                end
                ST_BUS_ADDR: begin
                    if (HREADY_I) begin
                        state_reg    <= ST_BUS_DATA;
                        byte_cnt_reg <= '0;
                    end
                end
                ST_BUS_DATA: begin
                    if (HREADY_I) begin
                        state_reg    <= ST_SEND;
                        byte_cnt_reg <= '0;
                        resp_reg     <= HRDATA_I;
                        err_reg      <= HRESP_I;
                        guard_reg    <= 1'b0;
                    end
                end
                ST_SEND: begin
                    // the guard cycle lets the core's busy flag catch up
                    if (tx_valid_reg) begin
                        guard_reg <= 1'b1;
                        if (last_byte) begin
                            state_reg    <= ST_IDLE;
                            byte_cnt_reg <= '0;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                            resp_reg     <= {resp_reg[23:0], 8'h00};
                        end
                    end else if (guard_reg) begin
                        guard_reg <= 1'b0;
                    end else if (!tx_busy) begin
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= err_reg      ? RSP_ERR :
                                        is_write_reg ? RSP_OK  : resp_reg[31:24];
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign HTRANS_O = (state_reg == ST_BUS_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR_O  = haddr_reg;
    assign HWRITE_O = hwrite_reg;
    assign HWDATA_O = hwdata_reg;
    assign HSIZE_O  = HSIZE_WORD;
    assign BUSY_O   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_ahb_bridge.sv
// Directed bench for uart_ahb_bridge: serial frames in, AHB slave model with
// programmable wait states, serial responses decoded and compared.
module tb_uart_ahb_bridge;

    logic        HCLK_I = 1'b0;
    logic        HRESET_I = 1'b1;
    logic        RX_I = 1'b1;
    logic        TX_O;
    logic [31:0] HADDR_O;
    logic [1:0]  HTRANS_O;
    logic        HWRITE_O;
    logic [2:0]  HSIZE_O;
    logic [31:0] HWDATA_O;
    logic [31:0] HRDATA_I = 32'h0;
    logic        HREADY_I = 1'b1;
    logic        HRESP_I = 1'b0;
    logic        BUSY_O;

    int n_cmp = 0;
    int n_err = 0;

    // slave configuration (written by the main sequence)
    int          addr_waits = 0;
    int          data_waits = 0;
    logic [31:0] rd_word = 32'h0;
    logic        rd_err = 1'b0;

    // slave model state
    int sphase = 0;
    int swcnt = 0;

    // bus monitor
    int          xfer_cnt = 0;
    int          nonseq_cycles = 0;
    int          unstable_cnt = 0;
    logic [31:0] last_addr = 32'h0;
    logic        last_write = 1'b0;
    logic [31:0] seen_wdata = 32'h0;
    logic        in_dphase = 1'b0;
    logic        prev_nonseq = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        prev_write = 1'b0;

    // TX decoder
    logic [7:0] tx_q[$];
    logic [7:0] tx_b;

    logic [7:0] frame [9];

    uart_ahb_bridge #(.CLK_ADD(11'd2047), .TIMEOUT(24'd100)) dut (
        .HCLK_I   (HCLK_I),
        .HRESET_I (HRESET_I),
        .RX_I     (RX_I),
        .TX_O     (TX_O),
        .HADDR_O  (HADDR_O),
        .HTRANS_O (HTRANS_O),
        .HWRITE_O (HWRITE_O),
        .HSIZE_O  (HSIZE_O),
        .HWDATA_O (HWDATA_O),
        .HRDATA_I (HRDATA_I),
        .HREADY_I (HREADY_I),
        .HRESP_I  (HRESP_I),
        .BUSY_O   (BUSY_O)
    );

    always #5 HCLK_I = ~HCLK_I;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // AHB slave: updates just after each rising edge
    always @(posedge HCLK_I) begin
        #1;
        if (HRESET_I) begin
            sphase   = 0;
            HREADY_I = 1'b1;
            HRESP_I  = 1'b0;
            HRDATA_I = 32'h0;
        end else begin
            case (sphase)
                0: begin
                    HREADY_I = 1'b1;
                    HRESP_I  = 1'b0;
                    HRDATA_I = 32'h0;
                    if (HTRANS_O == 2'b10) begin
                        if (addr_waits == 0) sphase = 2;
                        else begin HREADY_I = 1'b0; swcnt = 1; sphase = 1; end
                    end
                end
                1: begin
                    if (swcnt == addr_waits) begin HREADY_I = 1'b1; sphase = 2; end
                    else swcnt++;
                end
                2: begin
                    if (data_waits == 0) begin
                        HREADY_I = 1'b1; HRDATA_I = rd_word; HRESP_I = rd_err; sphase = 4;
                    end else begin
                        HREADY_I = 1'b0; swcnt = 1; sphase = 3;
                    end
                end
                3: begin
                    if (swcnt == data_waits) begin
                        HREADY_I = 1'b1; HRDATA_I = rd_word; HRESP_I = rd_err; sphase = 4;
                    end else swcnt++;
                end
                default: begin
                    HREADY_I = 1'b1; HRESP_I = 1'b0; HRDATA_I = 32'h0; sphase = 0;
                end
            endcase
        end
    end

    always @(negedge HCLK_I) begin
        if (HRESET_I) begin
            in_dphase   = 1'b0;
            prev_nonseq = 1'b0;
        end else begin
            if (in_dphase && HREADY_I) begin
                seen_wdata = HWDATA_O;
                in_dphase  = 1'b0;
            end
            if (HTRANS_O == 2'b10) begin
                nonseq_cycles++;
                if (prev_nonseq && (HADDR_O !== prev_addr || HWRITE_O !== prev_write))
                    unstable_cnt++;
                if (HREADY_I) begin
                    xfer_cnt++;
                    last_addr  = HADDR_O;
                    last_write = HWRITE_O;
                    in_dphase  = 1'b1;
                end
            end
            prev_nonseq = (HTRANS_O == 2'b10) && !HREADY_I;
            prev_addr   = HADDR_O;
            prev_write  = HWRITE_O;
        end
    end

    // one bit = 8 clocks at CLK_ADD=2047; sample near mid-bit
    initial begin
        forever begin
            @(negedge HCLK_I);
            if (TX_O === 1'b0) begin
                repeat (11) @(negedge HCLK_I);
                for (int i = 0; i < 8; i++) begin
                    tx_b[i] = TX_O;
                    if (i < 7) repeat (8) @(negedge HCLK_I);
                end
                repeat (8) @(negedge HCLK_I);
                tx_q.push_back(tx_b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge HCLK_I);
        RX_I = 1'b0;
        repeat (8) @(negedge HCLK_I);
        for (int i = 0; i < 8; i++) begin
            RX_I = b[i];
            repeat (8) @(negedge HCLK_I);
        end
        RX_I = 1'b1;
        repeat (7) @(negedge HCLK_I);
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_byte(frame[i]);
    endtask

    task automatic wait_tx(input int target, input string tag);
        int k;
        k = 0;
        while (tx_q.size() < target && k < 3000) begin
            @(negedge HCLK_I);
            k++;
        end
        check_val(tag, tx_q.size(), target);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge HCLK_I);
    endtask

    initial begin
        int bx;
        int bt;
        int bn;
        int bu;
        int k;

        repeat (5) @(negedge HCLK_I);
        check_val("rst_htrans", {30'd0, HTRANS_O}, 32'h0);
        check_val("rst_busy", {31'd0, BUSY_O}, 32'h0);
        check_val("rst_haddr", HADDR_O, 32'h0);
        check_val("rst_hwdata", HWDATA_O, 32'h0);
        check_val("rst_hwrite", {31'd0, HWRITE_O}, 32'h0);
        HRESET_I = 1'b0;
        settle(5);
        check_val("hsize", {29'd0, HSIZE_O}, 32'h2);
        check_val("idle_tx_line", {31'd0, TX_O}, 32'h1);

        // write
        bx = xfer_cnt; bt = tx_q.size();
        frame = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(9);
        wait_tx(bt + 1, "wr_tx_count");
        settle(200);
        check_val("wr_xfers", xfer_cnt - bx, 32'd1);
        check_val("wr_addr", last_addr, 32'h0000_1004);
        check_val("wr_hwrite", {31'd0, last_write}, 32'h1);
        check_val("wr_hwdata", seen_wdata, 32'hDEAD_BEEF);
        check_val("wr_resp", {24'd0, tx_q[bt]}, 32'h4B);
        check_val("wr_tx_total", tx_q.size() - bt, 32'd1);
        check_val("wr_busy_end", {31'd0, BUSY_O}, 32'h0);

        // read
        bx = xfer_cnt; bt = tx_q.size();
        rd_word = 32'h1234_5678;
        frame = '{8'h52, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(5);
        wait_tx(bt + 4, "rd_tx_count");
        settle(200);
        check_val("rd_xfers", xfer_cnt - bx, 32'd1);
        check_val("rd_addr", last_addr, 32'h0000_2000);
        check_val("rd_hwrite", {31'd0, last_write}, 32'h0);
        check_val("rd_data", {tx_q[bt], tx_q[bt+1], tx_q[bt+2], tx_q[bt+3]}, 32'h1234_5678);
        check_val("rd_tx_total", tx_q.size() - bt, 32'd4);

        // read with wait states, unaligned address
        bx = xfer_cnt; bt = tx_q.size(); bn = nonseq_cycles; bu = unstable_cnt;
        addr_waits = 3; data_waits = 2;
        rd_word = 32'hCAFE_F00D;
        frame = '{8'h52, 8'h00, 8'h00, 8'h30, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(5);
        wait_tx(bt + 4, "ws_tx_count");
        settle(200);
        check_val("ws_xfers", xfer_cnt - bx, 32'd1);
        check_val("ws_nonseq_cycles", nonseq_cycles - bn, 32'd4);
        check_val("ws_unstable", unstable_cnt - bu, 32'd0);
        check_val("ws_addr", last_addr, 32'h0000_300E);
        check_val("ws_data", {tx_q[bt], tx_q[bt+1], tx_q[bt+2], tx_q[bt+3]}, 32'hCAFE_F00D);
        addr_waits = 0; data_waits = 0;

        // error response on a write
        bx = xfer_cnt; bt = tx_q.size();
        rd_err = 1'b1;
        frame = '{8'h57, 8'h00, 8'h00, 8'h40, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(9);
        wait_tx(bt + 1, "err_tx_count");
        settle(200);
        rd_err = 1'b0;
        check_val("err_xfers", xfer_cnt - bx, 32'd1);
        check_val("err_resp", {24'd0, tx_q[bt]}, 32'h45);
        check_val("err_tx_total", tx_q.size() - bt, 32'd1);

        // garbage byte, truncated write, silence past the timeout
        bx = xfer_cnt; bt = tx_q.size();
        send_byte(8'h00);
        settle(3);
        check_val("garbage_busy", {31'd0, BUSY_O}, 32'h0);
        send_byte(8'h57);
        send_byte(8'hAA);
        check_val("partial_busy", {31'd0, BUSY_O}, 32'h1);
        settle(300);
        check_val("to_busy", {31'd0, BUSY_O}, 32'h0);
        check_val("to_xfers", xfer_cnt - bx, 32'd0);
        check_val("to_tx", tx_q.size() - bt, 32'd0);
        rd_word = 32'h0BAD_F00D;
        frame = '{8'h52, 8'h00, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(5);
        wait_tx(bt + 4, "to_rd_tx_count");
        settle(200);
        check_val("to_rd_addr", last_addr, 32'h0000_5000);
        check_val("to_rd_data", {tx_q[bt], tx_q[bt+1], tx_q[bt+2], tx_q[bt+3]}, 32'h0BAD_F00D);

        // reset during the data phase
        bx = xfer_cnt; bt = tx_q.size();
        data_waits = 20;
        frame = '{8'h57, 8'h00, 8'h00, 8'h60, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(9);
        k = 0;
        while (xfer_cnt == bx && k < 2000) begin
            @(negedge HCLK_I);
            k++;
        end
        check_val("rst_xfer_seen", xfer_cnt - bx, 32'd1);
        @(negedge HCLK_I);
        check_val("rst_busy_before", {31'd0, BUSY_O}, 32'h1);
        HRESET_I = 1'b1;
        @(negedge HCLK_I);
        check_val("rst_mid_htrans", {30'd0, HTRANS_O}, 32'h0);
        check_val("rst_mid_busy", {31'd0, BUSY_O}, 32'h0);
        check_val("rst_mid_haddr", HADDR_O, 32'h0);
        HRESET_I = 1'b0;
        data_waits = 0;
        settle(300);
        check_val("rst_no_tx", tx_q.size() - bt, 32'd0);
        check_val("rst_xfers", xfer_cnt - bx, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
